guess_entry: RTL

Player-side guess-entry block for the Mastermind game: the producer of the guess that the peg-feedback logic scores. Collects a four-digit colour guess from single-cycle button pulses into an edit buffer, commits it atomically to the `history0..3` outputs on submit, counts turns, and asserts `last_turn` with the final guess. Sits between the debounced button inputs and the feedback block, and consumes that block's `game_over` pulse to start a new game.

---
 rtl/guess_entry.sv | 133 +++++++++++++
 1 files changed

// File: rtl/guess_entry.sv
// guess_entry: player-side Mastermind guess entry. Buttons edit a 4-digit
// colour buffer; submit commits it atomically to history0..3 and counts turns.
// Ports: clk, rst (async, active-high); btn_inc/btn_next/btn_submit/game_over
// pulses in; history0..3, edit_digit, cursor, turn, last_turn, guess_valid,
// reject out. Optional: GUESS_ENTRY_DUP_CHECK_EN rejects repeated guesses.
module guess_entry #(
    parameter int NUM_TURNS  = 8,
    parameter int NUM_COLORS = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_inc,
    input  logic       btn_next,
    input  logic       btn_submit,
    input  logic       game_over,
    output logic [2:0] history0,
    output logic [2:0] history1,
    output logic [2:0] history2,
    output logic [2:0] history3,
    output logic [2:0] edit_digit,
    output logic [1:0] cursor,
    output logic [3:0] turn,
    output logic       last_turn,
    output logic       guess_valid,
    output logic       reject
);

    typedef enum logic [1:0] {
        EDIT   = 2'd0,
        COMMIT = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t     state, state_next;
    logic [2:0] digits [4];

    logic do_clear, do_commit, do_reject, do_next, do_inc;
    logic same_guess;

    // Matches the previously committed guess (only meaningful once turn > 0).
    assign same_guess = (turn != 4'd0)
                     && (digits[0] == history0) && (digits[1] == history1)
                     && (digits[2] == history2) && (digits[3] == history3);

    assign edit_digit = digits[cursor];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= EDIT;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        do_clear   = 1'b0;
        do_commit  = 1'b0;
        do_reject  = 1'b0;
        do_next    = 1'b0;
        do_inc     = 1'b0;
        if (game_over) begin
            do_clear   = 1'b1;
            state_next = EDIT;
        end else begin
            unique case (state)
                EDIT: begin
                    if (btn_submit) begin
`ifdef GUESS_ENTRY_DUP_CHECK_EN
                        if (same_guess) begin
                            do_reject = 1'b1;
                        end else begin
                            do_commit  = 1'b1;
                            state_next = COMMIT;
                        end
`else
                        do_commit  = 1'b1;
                        state_next = COMMIT;
`endif
                    end else if (btn_next) begin
                        do_next = 1'b1;
                    end else if (btn_inc) begin
                        do_inc = 1'b1;
                    end
                end
                COMMIT: state_next = last_turn ? DONE : EDIT;
                DONE:   state_next = DONE;
                default: state_next = EDIT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) digits[i] <= 3'd0;
            history0    <= 3'd0;
            history1    <= 3'd0;
            history2    <= 3'd0;
            history3    <= 3'd0;
            cursor      <= 2'd0;
            turn        <= 4'd0;
            last_turn   <= 1'b0;
            guess_valid <= 1'b0;
            reject      <= 1'b0;
        end else begin
            guess_valid <= 1'b0;
            reject      <= do_reject;
            if (do_clear) begin
                for (int i = 0; i < 4; i++) digits[i] <= 3'd0;
                history0  <= 3'd0;
                history1  <= 3'd0;
                history2  <= 3'd0;
                history3  <= 3'd0;
                cursor    <= 2'd0;
                turn      <= 4'd0;
                last_turn <= 1'b0;
            end else if (do_commit) begin
                history0    <= digits[0];
                history1    <= digits[1];
                history2    <= digits[2];
                history3    <= digits[3];
                turn        <= turn + 4'd1;
                guess_valid <= 1'b1;
                last_turn   <= ((turn + 4'd1) == 4'(NUM_TURNS));
            end else if (do_next) begin
                cursor <= cursor + 2'd1;
            end else if (do_inc) begin
                if (digits[cursor] == 3'(NUM_COLORS - 1))
                    digits[cursor] <= 3'd0;
                else
                    digits[cursor] <= digits[cursor] + 3'd1;
            end
        end
    end

endmodule
